// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and defaults for the PWM capture block
//
// Purpose: control FSM state encoding and default counter/duty widths used by
// pwm_capture and pwm_div.
// Ports: none (package).
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // not armed: next rise only starts a measurement
    ST_ARMED  = 2'd1,  // measuring: next rise captures period/high time
    ST_DIVIDE = 2'd2   // divider computing the duty code
  } state_e;

  localparam int CNT_W_DEF  = 16;
  localparam int DUTY_W_DEF = 5;

endpackage

// File: rtl/pwm_div.sv
// rtl/pwm_div.sv - restoring divider producing the duty code, one bit per clock
//
// Purpose: quotient = floor(dividend / divisor), DUTY_W+1 iterations, busy for
// DUTY_W+1 clocks after start. The caller guarantees dividend < divisor * 2^(DUTY_W+1)
// and a nonzero divisor; only the low DUTY_W quotient bits are presented.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      load operands and begin (ignored while abort is high)
//   abort      drop any divide in progress
//   dividend   CNT_W+DUTY_W bits
//   divisor    CNT_W bits
//   busy       divide in progress
//   done       high during the final iteration cycle; quotient valid then
//   quotient   DUTY_W-bit result (combinational, valid with done)
module pwm_div #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W+DUTY_W-1:0] dividend,
  input  logic [CNT_W-1:0]        divisor,
  output logic                    busy,
  output logic                    done,
  output logic [DUTY_W-1:0]       quotient
);

  localparam int QW = DUTY_W + 1;
  localparam int IW = $clog2(QW + 1);

  logic              busy_q, busy_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [QW-1:0]     bits_q, bits_d;  // dividend bits still to shift in, MSB first
  logic [QW-1:0]     quo_q, quo_d;
  logic [CNT_W:0]    trial;
  logic              q_bit;
  logic              last;
  logic [QW-1:0]     quo_full;

  always_comb begin
    trial    = {rem_q, bits_q[QW-1]};
    q_bit    = (trial >= {1'b0, dvs_q});
    last     = busy_q && (iter_q == IW'(QW - 1));
    quo_full = {quo_q[QW-2:0], q_bit};

    busy_d = busy_q;
    iter_d = iter_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    bits_d = bits_q;
    quo_d  = quo_q;

    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      iter_d = '0;
      // Upper dividend bits seed the remainder; they are below the divisor by contract.
      rem_d  = {1'b0, dividend[CNT_W+DUTY_W-1:QW]};
      bits_d = dividend[QW-1:0];
      dvs_d  = divisor;
      quo_d  = '0;
    end else if (busy_q) begin
      rem_d  = q_bit ? CNT_W'(trial - {1'b0, dvs_q}) : trial[CNT_W-1:0];
      bits_d = bits_q << 1;
      quo_d  = quo_full;
      iter_d = iter_q + IW'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      bits_q <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      iter_q <= iter_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      bits_q <= bits_d;
      quo_q  <= quo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = last && !abort;
  assign quotient = quo_full[DUTY_W-1:0];

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM receiver recovering period, high time and duty code
//
// Purpose: synchronizes pwm_in, measures period and high time between rising
// edges, divides to a DUTY_W-bit duty code and flags a stuck line on timeout.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   pwm_in       asynchronous PWM input
//   duty_cycle   last recovered duty code
//   period       last captured period (clk cycles)
//   high_time    last captured high time (clk cycles)
//   duty_valid   1-cycle pulse when outputs update
//   stuck_high   line timed out high
//   stuck_low    line timed out low
//   overrun      1-cycle pulse: capture dropped because the divider was busy
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              duty_valid,
  output logic              stuck_high,
  output logic              stuck_low,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d, s_q, s_d, p_q, p_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
  logic              timed_out_q, timed_out_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  period_q, period_d, high_time_q, high_time_d;
  logic              valid_q, valid_d, sh_q, sh_d, sl_q, sl_d, ovr_q, ovr_d;
  logic              rise, timeout, div_start, div_busy, div_done;
  logic [DUTY_W-1:0] div_q;

  always_comb begin
    sync1_d = pwm_in;
    s_d     = sync1_q;
    p_d     = s_q;
    rise    = s_q & ~p_q;
    // Fires once per stuck interval; a rise in the same cycle takes priority.
    timeout = (period_cnt_q == CNT_MAX) && !rise && !timed_out_q;

    if (rise)                        period_cnt_d = CNT_W'(1);
    else if (period_cnt_q != CNT_MAX) period_cnt_d = period_cnt_q + CNT_W'(1);
    else                             period_cnt_d = period_cnt_q;

    if (rise)                               high_cnt_d = CNT_W'(1);
    else if (s_q && high_cnt_q != CNT_MAX)  high_cnt_d = high_cnt_q + CNT_W'(1);
    else                                    high_cnt_d = high_cnt_q;

    if (rise)         timed_out_d = 1'b0;
    else if (timeout) timed_out_d = 1'b1;
    else              timed_out_d = timed_out_q;

    div_start = rise && (state_q == ST_ARMED);
  end

  pwm_div #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (timeout),
    .dividend ({high_cnt_q, {DUTY_W{1'b0}}}),
    .divisor  (period_cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    sh_d        = sh_q;
    sl_d        = sl_q;
    valid_d     = 1'b0;
    ovr_d       = rise && div_busy;

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (rise) begin
          state_d     = ST_DIVIDE;
          period_d    = period_cnt_q;
          high_time_d = high_cnt_q;
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          state_d = ST_ARMED;
          duty_d  = div_q;
          valid_d = 1'b1;
          sh_d    = 1'b0;
          sl_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      valid_d = 1'b1;
      sh_d    = s_q;
      sl_d    = ~s_q;
      duty_d  = s_q ? {DUTY_W{1'b1}} : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      p_q          <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      timed_out_q  <= 1'b0;
      duty_q       <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      valid_q      <= 1'b0;
      sh_q         <= 1'b0;
      sl_q         <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      s_q          <= s_d;
      p_q          <= p_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      timed_out_q  <= timed_out_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      valid_q      <= valid_d;
      sh_q         <= sh_d;
      sl_q         <= sl_d;
      ovr_q        <= ovr_d;
    end
  end

  assign duty_cycle = duty_q;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign duty_valid = valid_q;
  assign stuck_high = sh_q;
  assign stuck_low  = sl_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture (CNT_W=8 build)
module tb_pwm_capture;
  localparam int CNT_W  = 8;
  localparam int DUTY_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pwm_in = 1'b0;
  logic [DUTY_W-1:0] duty_cycle;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  high_time;
  logic              duty_valid, stuck_high, stuck_low, overrun;

  pwm_capture #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty_cycle (duty_cycle),
    .period     (period),
    .high_time  (high_time),
    .duty_valid (duty_valid),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  per;
    logic [CNT_W-1:0]  hi;
    logic              sh;
    logic              sl;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  longint vt[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     ov_cnt   = 0;
  int     ov0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every duty_valid pops one expected record.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ov_cnt++;
      if (duty_valid) begin
        vt.push_back($time);
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'd0, duty_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("duty_cycle", {27'd0, duty_cycle}, {27'd0, mon_e.duty});
          check("period",     {24'd0, period},     {24'd0, mon_e.per});
          check("high_time",  {24'd0, high_time},  {24'd0, mon_e.hi});
          check("stuck_high", {31'd0, stuck_high}, {31'd0, mon_e.sh});
          check("stuck_low",  {31'd0, stuck_low},  {31'd0, mon_e.sl});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic run_pwm(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      tick(h);
      pwm_in = 1'b0;
      tick(p - h);
    end
  endtask

  task automatic push(input int cnt, input int duty, input int per, input int hi,
                      input int sh, input int sl);
    exp_t e;
    e.duty = DUTY_W'(duty);
    e.per  = CNT_W'(per);
    e.hi   = CNT_W'(hi);
    e.sh   = sh[0];
    e.sl   = sl[0];
    for (int i = 0; i < cnt; i++) sb.push_back(e);
  endtask

  task automatic drain(input string name);
    tick(20);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_duty",    {27'd0, duty_cycle}, 0);
    check("rst_period",  {24'd0, period}, 0);
    check("rst_high",    {24'd0, high_time}, 0);
    check("rst_valid",   {31'd0, duty_valid}, 0);
    check("rst_stuck",   {30'd0, stuck_high, stuck_low}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    rst = 1'b0;
    tick(2);

    // 1: period 32, high 8 -> duty 8, first rise only arms
    vt.delete();
    ov0 = ov_cnt;
    push(3, 8, 32, 8, 0, 0);
    run_pwm(32, 8, 4);
    drain("t1_drain");
    check("t1_overrun", ov_cnt - ov0, 0);
    check("t1_nvalid", vt.size(), 3);
    if (vt.size() == 3) begin
      check("t1_spacing0", 32'((vt[1] - vt[0]) / 10), 32);
      check("t1_spacing1", 32'((vt[2] - vt[1]) / 10), 32);
    end

    // 2: period 40, high 39 -> 31; high 1 -> 0
    do_reset();
    push(2, 31, 40, 39, 0, 0);
    run_pwm(40, 39, 3);
    drain("t2a_drain");
    do_reset();
    push(2, 0, 40, 1, 0, 0);
    run_pwm(40, 1, 3);
    drain("t2b_drain");

    // 3: stuck high, then recovery
    do_reset();
    push(1, 31, 0, 0, 1, 0);
    pwm_in = 1'b1;
    tick(300);
    check("t3_drain", sb.size(), 0);
    check("t3_stuck_high", {31'd0, stuck_high}, 1);
    check("t3_duty", {27'd0, duty_cycle}, 31);
    pwm_in = 1'b0;
    tick(10);
    push(2, 8, 32, 8, 0, 0);
    run_pwm(32, 8, 1);
    check("t3_hold_flag", {31'd0, stuck_high}, 1);
    run_pwm(32, 8, 2);
    drain("t3_drain2");
    check("t3_cleared", {31'd0, stuck_high}, 0);

    // 4: stuck low after activity, period/high_time retained
    do_reset();
    push(2, 8, 32, 8, 0, 0);
    run_pwm(32, 8, 3);
    push(1, 0, 32, 8, 0, 1);
    tick(300);
    check("t4_drain", sb.size(), 0);
    check("t4_stuck_low", {31'd0, stuck_low}, 1);
    tick(100);
    check("t4_duty", {27'd0, duty_cycle}, 0);

    // 5: period 4 -> every other capture dropped with overrun
    do_reset();
    ov0 = ov_cnt;
    push(5, 16, 4, 2, 0, 0);
    run_pwm(4, 2, 10);
    drain("t5_drain");
    check("t5_overruns", ov_cnt - ov0, 4);

    // 6: async reset mid-divide
    do_reset();
    run_pwm(32, 8, 1);
    pwm_in = 1'b1;
    tick(4);
    check("t6_pre_period", {24'd0, period}, 32);
    check("t6_pre_high", {24'd0, high_time}, 8);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_period", {24'd0, period}, 0);
    check("t6_async_high", {24'd0, high_time}, 0);
    check("t6_async_duty", {27'd0, duty_cycle}, 0);
    pwm_in = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(40);
    check("t6_no_valid", sb.size(), 0);
    check("t6_period_after", {24'd0, period}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
